// File: rtl/tag_sysid_uptime.sv
// tag_sysid_uptime
//   System-ID and uptime peripheral on an Avalon-MM slave port. Presents the
//   read-only ID, build timestamp and capability words, a byte-writable
//   scratch register, and a prescaled 64-bit uptime counter. Reading
//   UPTIME_LO latches the upper half of the same count value, so a following
//   UPTIME_HI read never shows a carry that happened between the two reads.
//   Reads have a fixed latency of one cycle. There is no waitrequest.
//
// Ports
//   clock          sole clock, rising edge
//   reset          synchronous, active-high
//   address[2:0]   word address
//   read / write   one-cycle access strobes
//   writedata[31:0], byteenable[3:0]   write data and write byte lanes
//   readdata[31:0] registered read data, zero unless readdatavalid is high
//   readdatavalid  high in the cycle after an accepted read
//   tick           one-cycle pulse, registered with each uptime increment
//
// Register map (word addresses)
//   0 ID          RO  SYS_ID
//   1 TIMESTAMP   RO  TIMESTAMP
//   2 CAPS        RO  {VERSION, 8'h00, TICK_DIV}
//   3 SCRATCH     RW  byte-enabled
//   4 UPTIME_LO   RO  count[31:0]; the read latches count[63:32]
//   5 UPTIME_HI   RO  latched upper half
//   6 CTRL        bit0 RUN (RW), bit1 CLR (write-1 pulse, reads 0)
//   7 reserved    reads 0

module tag_sysid_uptime #(
    parameter logic [31:0] SYS_ID        = 32'hC0DE_0001,
    parameter logic [31:0] TIMESTAMP     = 32'd0,
    parameter logic [7:0]  VERSION       = 8'd2,
    parameter logic [15:0] TICK_DIV      = 16'd50,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        tick
);

    localparam logic [15:0] TICK_LAST = TICK_DIV - 16'd1;

    logic [63:0] count;
    logic [15:0] prescaler;
    logic [31:0] shadow_hi;
    logic [31:0] scratch;
    logic        run;

    logic        ctrl_wr;
    logic        clr_req;
    logic        tick_due;
    logic [31:0] rd_mux;

    // RUN and CLR both live in byte lane 0 of CTRL.
    assign ctrl_wr  = write && (address == 3'd6) && byteenable[0];
    assign clr_req  = ctrl_wr && writedata[1];
    assign tick_due = run && (prescaler == TICK_LAST);

    // The mux sees the state at the start of the cycle, so a write to the
    // same address in the same cycle is not visible to the read.
    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:    rd_mux = SYS_ID;
            3'd1:    rd_mux = TIMESTAMP;
            3'd2:    rd_mux = {VERSION, 8'h00, TICK_DIV};
            3'd3:    rd_mux = scratch;
            3'd4:    rd_mux = count[31:0];
            3'd5:    rd_mux = shadow_hi;
            3'd6:    rd_mux = {31'd0, run};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
            shadow_hi     <= '0;
        end else begin
            readdatavalid <= read;
            readdata      <= read ? rd_mux : 32'd0;
            if (read && (address == 3'd4)) begin
                shadow_hi <= count[63:32];
            end
        end
    end

    // CLR wins over an increment due in the same cycle and suppresses its
    // tick. RUN gates the counter with its current value; a new RUN written
    // this cycle takes effect from the next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= '0;
            prescaler <= '0;
            tick      <= 1'b0;
            run       <= 1'b1;
        end else begin
            if (clr_req) begin
                count     <= '0;
                prescaler <= '0;
                tick      <= 1'b0;
            end else if (tick_due) begin
                count     <= count + 64'd1;
                prescaler <= '0;
                tick      <= 1'b1;
            end else begin
                tick <= 1'b0;
                if (run) begin
                    prescaler <= prescaler + 16'd1;
                end
            end
            if (ctrl_wr) begin
                run <= writedata[0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scratch <= SCRATCH_RESET;
        end else if (write && (address == 3'd3)) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    scratch[8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_tag_sysid_uptime.sv
// Testbench for tag_sysid_uptime. A cycle-level behavioural model predicts
// readdata, readdatavalid and tick after every rising edge, and these are
// compared on the falling edge. Directed sequences add literal expectations
// on read data and tick counts.

module tb_tag_sysid_uptime;

    localparam logic [15:0] TICK_DIV = 16'd50;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        tick;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    tag_sysid_uptime #(
        .SYS_ID        (32'hC0DE_0001),
        .TIMESTAMP     (32'd0),
        .VERSION       (8'd2),
        .TICK_DIV      (TICK_DIV),
        .SCRATCH_RESET (32'h0000_0000)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .tick          (tick)
    );

    // Model state. m_since counts the run cycles since the last tick; a tick
    // happens on the cycle that completes TICK_DIV of them.
    logic [63:0] m_count;
    int          m_since;
    logic [31:0] m_shadow;
    logic [31:0] m_scratch;
    logic        m_run;
    logic        m_rdv;
    logic [31:0] m_rdata;
    logic        m_tick;
    logic        m_valid = 1'b0;

    logic [63:0] force_val;
    logic [15:0] force_pre;

    function automatic logic [31:0] m_reg(input logic [2:0] a);
        case (a)
            3'd0:    return 32'hC0DE_0001;
            3'd1:    return 32'h0000_0000;
            3'd2:    return 32'h0200_0032;
            3'd3:    return m_scratch;
            3'd4:    return m_count[31:0];
            3'd5:    return m_shadow;
            3'd6:    return m_run ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_count = 64'd0; m_since = 0; m_shadow = 32'd0;
            m_scratch = 32'd0; m_run = 1'b1;
            m_rdv = 1'b0; m_rdata = 32'd0; m_tick = 1'b0;
        end else begin
            m_rdv   = read;
            m_rdata = read ? m_reg(address) : 32'd0;
            if (read && address == 3'd4) m_shadow = m_count[63:32];
            m_tick = 1'b0;
            if (write && address == 3'd6 && byteenable[0] && writedata[1]) begin
                m_count = 64'd0;
                m_since = 0;
            end else if (m_run) begin
                m_since = m_since + 1;
                if (m_since == int'(TICK_DIV)) begin
                    m_since = 0;
                    m_count = m_count + 64'd1;
                    m_tick  = 1'b1;
                end
            end
            if (write && address == 3'd6 && byteenable[0]) m_run = writedata[0];
            if (write && address == 3'd3) begin
                for (int b = 0; b < 4; b++)
                    if (byteenable[b]) m_scratch[8*b +: 8] = writedata[8*b +: 8];
            end
        end
        m_valid = 1'b1;
    end

    always @(negedge clock) begin
        if (m_valid) begin
            checks++;
            if (readdatavalid !== m_rdv) begin
                errors++;
                $display("FAIL cyc_rdv t=%0t got %b want %b", $time, readdatavalid, m_rdv);
            end
            checks++;
            if (readdata !== m_rdata) begin
                errors++;
                $display("FAIL cyc_rdata t=%0t got %h want %h", $time, readdata, m_rdata);
            end
            checks++;
            if (tick !== m_tick) begin
                errors++;
                $display("FAIL cyc_tick t=%0t got %b want %b", $time, tick, m_tick);
            end
        end
    end

    logic [31:0] got_q[$];
    int          n_ticks = 0;

    always @(negedge clock) begin
        if (readdatavalid === 1'b1) got_q.push_back(readdata);
        if (tick === 1'b1) n_ticks++;
    end

    task automatic cyc();
        @(negedge clock);
        #1;
    endtask

    task automatic rd(input logic [2:0] a);
        read = 1'b1; address = a;
        cyc();
        read = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        write = 1'b1; address = a; writedata = d; byteenable = be;
        cyc();
        write = 1'b0; byteenable = 4'h0;
    endtask

    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input string name, input logic [31:0] exp);
        if (got_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s got no read data want %h", name, exp);
        end else begin
            lit(name, 64'(got_q.pop_front()), 64'(exp));
        end
    endtask

    // Counter must be stopped (RUN=0) when this is called so that the value
    // left behind after release is exactly the forced one.
    task automatic force_count(input logic [63:0] v, input logic [15:0] p);
        force_val = v;
        force_pre = p;
        force dut.count = force_val;
        force dut.prescaler = force_pre;
        m_count = v;
        m_since = int'(p);
        cyc();
        release dut.count;
        release dut.prescaler;
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        bit found;
        reset = 1'b1; read = 1'b0; write = 1'b0; address = 3'd0;
        writedata = 32'd0; byteenable = 4'h0;
        repeat (3) cyc();
        lit("rst_rdv", 64'(readdatavalid), 64'd0);
        lit("rst_rdata", 64'(readdata), 64'd0);
        lit("rst_tick", 64'(tick), 64'd0);

        // Free-running for 500 cycles: 10 ticks, LO=10, HI=0.
        reset = 1'b0;
        t0 = n_ticks;
        repeat (500) cyc();
        lit("ticks_500", 64'(n_ticks - t0), 64'd10);
        rd(3'd4); rd(3'd5);
        pop_chk("uptime_lo_10", 32'd10);
        pop_chk("uptime_hi_0", 32'd0);

        // Constant registers, back to back.
        rd(3'd0); rd(3'd1); rd(3'd2); rd(3'd7); rd(3'd6);
        pop_chk("id", 32'hC0DE_0001);
        pop_chk("timestamp", 32'h0000_0000);
        pop_chk("caps", 32'h0200_0032);
        pop_chk("addr7", 32'd0);
        pop_chk("ctrl_run", 32'd1);

        // Scratch byte lanes and same-cycle read/write ordering.
        wr(3'd3, 32'hAABB_CCDD, 4'hF);
        wr(3'd3, 32'h1122_3344, 4'b0101);
        rd(3'd3);
        pop_chk("scratch_be", 32'hAA22_CC44);
        read = 1'b1; write = 1'b1; address = 3'd3;
        writedata = 32'h5566_7788; byteenable = 4'hF;
        cyc();
        read = 1'b0; write = 1'b0; byteenable = 4'h0;
        rd(3'd3);
        pop_chk("scratch_rw_old", 32'hAA22_CC44);
        pop_chk("scratch_rw_new", 32'h5566_7788);
        wr(3'd7, 32'hFFFF_FFFF, 4'hF);
        wr(3'd0, 32'hFFFF_FFFF, 4'hF);
        rd(3'd7); rd(3'd0);
        pop_chk("addr7_wr_ignored", 32'd0);
        pop_chk("id_wr_ignored", 32'hC0DE_0001);

        // Stopped counter.
        wr(3'd6, 32'd0, 4'hF);
        t0 = n_ticks;
        repeat (200) cyc();
        lit("ticks_stopped", 64'(n_ticks - t0), 64'd0);
        rd(3'd6);
        pop_chk("ctrl_stopped", 32'd0);

        // Carry across the low word between LO and HI reads.
        force_count(64'h0000_0000_FFFF_FFFF, TICK_DIV - 16'd1);
        wr(3'd6, 32'd1, 4'h1);
        rd(3'd4); rd(3'd5);
        pop_chk("snap_lo_pre", 32'hFFFF_FFFF);
        pop_chk("snap_hi_pre", 32'd0);
        repeat (50) cyc();
        rd(3'd4); rd(3'd5);
        pop_chk("snap_lo_post", 32'd1);
        pop_chk("snap_hi_post", 32'd1);

        // CLR in the cycle an increment is due.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_run && m_since == int'(TICK_DIV) - 1) found = 1'b1;
            else cyc();
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL clr_align got no tick-due cycle want one within 200");
        end
        wr(3'd6, 32'd3, 4'h1);
        lit("clr_no_tick", 64'(tick), 64'd0);
        rd(3'd4);
        pop_chk("clr_lo", 32'd0);
        repeat (60) cyc();
        rd(3'd4);
        pop_chk("clr_resume", 32'd1);

        // Full 64-bit wrap.
        wr(3'd6, 32'd0, 4'h1);
        force_count(64'hFFFF_FFFF_FFFF_FFFF, TICK_DIV - 16'd1);
        wr(3'd6, 32'd1, 4'h1);
        cyc();
        lit("wrap_tick", 64'(tick), 64'd1);
        rd(3'd4); rd(3'd5);
        pop_chk("wrap_lo", 32'd0);
        pop_chk("wrap_hi", 32'd0);

        // Reset the cycle after a read, then reset together with a read.
        rd(3'd3);
        pop_chk("pre_reset_scratch", 32'h5566_7788);
        reset = 1'b1;
        cyc();
        lit("reset_after_read_rdv", 64'(readdatavalid), 64'd0);
        read = 1'b1; address = 3'd3;
        cyc();
        read = 1'b0;
        lit("reset_drop_rdv", 64'(readdatavalid), 64'd0);
        lit("reset_drop_q", 64'(got_q.size()), 64'd0);
        reset = 1'b0;
        rd(3'd3); rd(3'd6); rd(3'd4); rd(3'd5);
        pop_chk("post_reset_scratch", 32'd0);
        pop_chk("post_reset_run", 32'd1);
        pop_chk("post_reset_lo", 32'd0);
        pop_chk("post_reset_hi", 32'd0);
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
